// File: rtl/angle_pkg.sv
// Shared constants for the angle-to-sin/cos converter: angle landmarks, CORDIC gain, atan table, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package angle_pkg;

    localparam logic [31:0] ANGLE_90  = 32'd754974720;
    localparam logic [31:0] ANGLE_180 = 32'd1509949440;
    localparam logic [31:0] ANGLE_270 = 32'd2264924160;
    localparam logic [31:0] ANGLE_360 = 32'd3019898880;

    localparam int CORDIC_K_Q14 = 9949;
    localparam int ATAN_N       = 20;

    // atan(2^-i) in degrees x 2^23
    localparam logic [31:0] ATAN_TAB [ATAN_N] = '{
        32'd377487360, 32'd222843801, 32'd117744544, 32'd59768969,
        32'd30000467,  32'd15014858,  32'd7509261,   32'd3754860,
        32'd1877459,   32'd938733,    32'd469367,    32'd234683,
        32'd117342,    32'd58671,     32'd29335,     32'd14668,
        32'd7334,      32'd3667,      32'd1833,      32'd917
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_ITER,
        ST_FIX,
        ST_OUTPUT
    } state_t;

endpackage

// File: rtl/cordic_step.sv
// One CORDIC rotation-mode micro-rotation: rotates (x, y) by -/+atan(2^-i) towards z = 0.
// Latency: combinational.
// Backpressure: none.
module cordic_step
    import angle_pkg::*;
#(
    parameter int XY_W = 22
) (
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic signed [32:0]     z,
    input  logic [4:0]             i,
    output logic signed [XY_W-1:0] x_nxt,
    output logic signed [XY_W-1:0] y_nxt,
    output logic signed [32:0]     z_nxt
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [32:0]     atan_i;

    always_comb begin
        x_sh   = x >>> i;
        y_sh   = y >>> i;
        atan_i = {1'b0, ATAN_TAB[i]};
        // z >= 0 counts as d = +1
        if (!z[32]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - atan_i;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + atan_i;
        end
    end

endmodule

// File: rtl/angle_sincos.sv
// Converts alpha/beta/gamma angles to Q2.14 sin/cos pairs with one time-shared iterative CORDIC.
// Latency: o_done in the cycle after edge T0 + 3*(ITERATIONS+2) + 1.
// Backpressure: i_start ignored while o_busy; results held until the next o_done.
module angle_sincos
    import angle_pkg::*;
#(
    parameter int ITERATIONS = 16,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [31:0]                 i_alpha,
    input  logic [31:0]                 i_beta,
    input  logic [31:0]                 i_gamma,
    output logic                        o_busy,
    output logic                        o_done,
    output logic signed [OUT_WIDTH-1:0] o_sin_alpha,
    output logic signed [OUT_WIDTH-1:0] o_cos_alpha,
    output logic signed [OUT_WIDTH-1:0] o_sin_beta,
    output logic signed [OUT_WIDTH-1:0] o_cos_beta,
    output logic signed [OUT_WIDTH-1:0] o_sin_gamma,
    output logic signed [OUT_WIDTH-1:0] o_cos_gamma
);

    // x/y carry GUARD extra fraction bits below the Q2.14 output LSB
    localparam int GUARD = 4;
    localparam int XY_W  = OUT_WIDTH + 6;
    localparam logic signed [XY_W-1:0] K_INIT    = XY_W'(CORDIC_K_Q14 << (OUT_WIDTH - 12));
    localparam logic signed [XY_W-1:0] RND_HALF  = XY_W'(1 << (GUARD - 1));
    localparam logic signed [XY_W-1:0] ONE_X     = XY_W'(1 << (OUT_WIDTH - 2));
    localparam logic [4:0]             LAST_ITER = 5'(ITERATIONS - 1);

    state_t state, state_nxt;
    logic capture, do_reduce, do_iter, do_fix, do_out;

    logic [31:0]            cap_ang [3];
    logic [1:0]             idx;
    logic [4:0]             iter;
    logic [1:0]             quad;
    logic signed [XY_W-1:0] x_r, y_r, x_nxt, y_nxt;
    logic signed [32:0]     z_r, z_nxt;

    logic [31:0]            ang_sel, ang_wrap, ang_base;
    logic [1:0]             quad_red;
    logic signed [32:0]     z_red;

    logic signed [XY_W-1:0]      sin_full, cos_full;
    logic signed [OUT_WIDTH-1:0] sin_fix, cos_fix;
    logic signed [OUT_WIDTH-1:0] hold_sin [3];
    logic signed [OUT_WIDTH-1:0] hold_cos [3];

    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [XY_W-1:0] v);
        logic signed [XY_W-1:0] t;
        t = (v + RND_HALF) >>> GUARD;
        if (t > ONE_X)
            t = ONE_X;
        else if (t < -ONE_X)
            t = -ONE_X;
        return t[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_start) state_nxt = ST_REDUCE;
            ST_REDUCE: state_nxt = ST_ITER;
            ST_ITER:   if (iter == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:    state_nxt = (idx == 2'd2) ? ST_OUTPUT : ST_REDUCE;
            ST_OUTPUT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        capture   = (state == ST_IDLE) && i_start;
        do_reduce = (state == ST_REDUCE);
        do_iter   = (state == ST_ITER);
        do_fix    = (state == ST_FIX);
        do_out    = (state == ST_OUTPUT);
        o_busy    = (state != ST_IDLE);
    end

    // Fold into [0, 360) once, then into the first quadrant
    always_comb begin
        ang_sel  = cap_ang[idx];
        ang_wrap = (ang_sel >= ANGLE_360) ? (ang_sel - ANGLE_360) : ang_sel;
        if (ang_wrap >= ANGLE_270) begin
            quad_red = 2'd3;
            ang_base = ANGLE_270;
        end else if (ang_wrap >= ANGLE_180) begin
            quad_red = 2'd2;
            ang_base = ANGLE_180;
        end else if (ang_wrap >= ANGLE_90) begin
            quad_red = 2'd1;
            ang_base = ANGLE_90;
        end else begin
            quad_red = 2'd0;
            ang_base = 32'd0;
        end
        z_red = $signed({1'b0, ang_wrap - ang_base});
    end

    cordic_step #(
        .XY_W (XY_W)
    ) u_step (
        .x     (x_r),
        .y     (y_r),
        .z     (z_r),
        .i     (iter),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_comb begin
        case (quad)
            2'd0: begin sin_full = y_r;  cos_full = x_r;  end
            2'd1: begin sin_full = x_r;  cos_full = -y_r; end
            2'd2: begin sin_full = -y_r; cos_full = -x_r; end
            default: begin sin_full = -x_r; cos_full = y_r; end
        endcase
        sin_fix = round_sat(sin_full);
        cos_fix = round_sat(cos_full);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < 3; k++) begin
                cap_ang[k]  <= '0;
                hold_sin[k] <= '0;
                hold_cos[k] <= '0;
            end
            idx         <= '0;
            iter        <= '0;
            quad        <= '0;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            o_done      <= 1'b0;
            o_sin_alpha <= '0;
            o_cos_alpha <= '0;
            o_sin_beta  <= '0;
            o_cos_beta  <= '0;
            o_sin_gamma <= '0;
            o_cos_gamma <= '0;
        end else begin
            o_done <= do_out;
            if (capture) begin
                cap_ang[0] <= i_alpha;
                cap_ang[1] <= i_beta;
                cap_ang[2] <= i_gamma;
                idx        <= 2'd0;
            end
            if (do_reduce) begin
                x_r  <= K_INIT;
                y_r  <= '0;
                z_r  <= z_red;
                quad <= quad_red;
                iter <= '0;
            end
            if (do_iter) begin
                x_r  <= x_nxt;
                y_r  <= y_nxt;
                z_r  <= z_nxt;
                iter <= iter + 5'd1;
            end
            if (do_fix) begin
                hold_sin[idx] <= sin_fix;
                hold_cos[idx] <= cos_fix;
                idx           <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            if (do_out) begin
                o_sin_alpha <= hold_sin[0];
                o_cos_alpha <= hold_cos[0];
                o_sin_beta  <= hold_sin[1];
                o_cos_beta  <= hold_cos[1];
                o_sin_gamma <= hold_sin[2];
                o_cos_gamma <= hold_cos[2];
            end
        end
    end

endmodule

// File: tb/tb_angle_sincos.sv
// Directed-vector bench for angle_sincos: table of hand-computed results, timing corners, full-step sweep.
module tb_angle_sincos;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] alpha = '0, beta = '0, gamma = '0;
    logic        busy, done;
    logic signed [15:0] sa, ca, sb, cb, sg, cg;
    logic [95:0] all_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign all_out = {sa, ca, sb, cb, sg, cg};

    angle_sincos #(
        .ITERATIONS (16),
        .OUT_WIDTH  (16)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_alpha     (alpha),
        .i_beta      (beta),
        .i_gamma     (gamma),
        .o_busy      (busy),
        .o_done      (done),
        .o_sin_alpha (sa),
        .o_cos_alpha (ca),
        .o_sin_beta  (sb),
        .o_cos_beta  (cb),
        .o_sin_gamma (sg),
        .o_cos_gamma (cg)
    );

    typedef struct {
        logic [31:0] a, b, g;
        int s0, c0, s1, c1, s2, c2;
    } vec_t;

    vec_t tab [5];

    task automatic chk(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic chk_res(input string tag, input int s0, input int c0, input int s1,
                           input int c1, input int s2, input int c2, input int tol);
        chk({tag, "_sin_a"}, int'(sa), s0, tol);
        chk({tag, "_cos_a"}, int'(ca), c0, tol);
        chk({tag, "_sin_b"}, int'(sb), s1, tol);
        chk({tag, "_cos_b"}, int'(cb), c1, tol);
        chk({tag, "_sin_g"}, int'(sg), s2, tol);
        chk({tag, "_cos_g"}, int'(cg), c2, tol);
    endtask

    // Waits for o_done; outputs must not move on any cycle before it
    task automatic wait_done(input int budget, output int lat);
        logic [95:0] snap;
        bit moved;
        snap  = all_out;
        moved = 1'b0;
        lat   = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (all_out != snap) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL outputs_stable: changed=1, want changed=0 before o_done");
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
        int lat;
        alpha = a; beta = b; gamma = g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1, 0);
        wait_done(200, lat);
        chk("done_latency", lat, 55, 0);
        chk("busy_at_done", int'(busy), 0, 0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    function automatic logic [31:0] ang_of(input int n);
        return 32'(longint'(n) * 64'd4915200);
    endfunction

    function automatic int model(input int n, input bit want_cos);
        real r;
        r = n * 0.5859375 * 3.14159265358979 / 180.0;
        return $rtoi($floor(16384.0 * (want_cos ? $cos(r) : $sin(r)) + 0.5));
    endfunction

    initial begin
        int lat, nd;
        int dt [3];

        tab[0] = '{32'd0,          32'd754974720,  32'd1509949440, 0, 16384, 16384, 0, 0, -16384};
        tab[1] = '{32'd4915200,    32'd3014983680, 32'd2264924160, 168, 16383, -168, 16383, -16384, 0};
        tab[2] = '{32'd251658240,  32'd377487360,  32'd503316480,  8192, 14189, 11585, 11585, 14189, 8192};
        tab[3] = '{32'd1006632960, 32'd1887436800, 32'd2516582400, 14189, -8192, -11585, -11585, -14189, 8192};
        tab[4] = '{32'd3019898880, 32'd3774873600, 32'd4294967295, 0, 16384, 16384, 0, 7692, -14466};

        // Power-on reset held for 5 cycles
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_res("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_done", int'(done), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            run(tab[v].a, tab[v].b, tab[v].g);
            chk_res($sformatf("vec%0d", v), tab[v].s0, tab[v].c0, tab[v].s1,
                    tab[v].c1, tab[v].s2, tab[v].c2, 4);
        end

        // Inputs change at T0+5; results must follow the captured values
        alpha = tab[2].a; beta = tab[2].b; gamma = tab[2].g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        alpha = tab[3].a; beta = tab[3].b; gamma = tab[3].g;
        wait_done(200, lat);
        chk("capture_latency", lat, 50, 0);
        chk_res("capture", tab[2].s0, tab[2].c0, tab[2].s1, tab[2].c1, tab[2].s2, tab[2].c2, 4);

        // Start pulse at T0+10 while busy must be ignored
        alpha = tab[3].a; beta = tab[3].b; gamma = tab[3].g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        alpha = tab[2].a; beta = tab[2].b; gamma = tab[2].g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, lat);
        chk("busy_pulse_latency", lat, 45, 0);
        chk_res("busy_pulse", tab[3].s0, tab[3].c0, tab[3].s1, tab[3].c1, tab[3].s2, tab[3].c2, 4);
        count_dones(80, nd);
        chk("busy_pulse_extra_done", nd, 0, 0);

        // Held i_start: back-to-back conversions every 56 cycles
        alpha = tab[0].a; beta = tab[0].b; gamma = tab[0].g;
        dt[0] = 0; dt[1] = 0; dt[2] = 0;
        nd = 0;
        start = 1'b1;
        for (int k = 1; k <= 250 && nd < 3; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dt[nd] = k;
                nd++;
            end
        end
        start = 1'b0;
        chk("held_done_count", nd, 3, 0);
        chk("held_interval_1", dt[1] - dt[0], 56, 0);
        chk("held_interval_2", dt[2] - dt[1], 56, 0);

        // Reset asserted mid-conversion around T0+20
        alpha = tab[3].a; beta = tab[3].b; gamma = tab[3].g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_res("midreset", 0, 0, 0, 0, 0, 0, 0);
        chk("midreset_busy", int'(busy), 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        count_dones(80, nd);
        chk("midreset_no_done", nd, 0, 0);
        chk_res("after_midreset", 0, 0, 0, 0, 0, 0, 0);
        chk("after_midreset_busy", int'(busy), 0, 0);

        // Every accumulator step below 360 degrees
        for (int c = 0; c < 205; c++) begin
            run(ang_of(3 * c), ang_of(3 * c + 1), ang_of(3 * c + 2));
            chk_res($sformatf("sweep%0d", 3 * c),
                    model(3 * c, 1'b0), model(3 * c, 1'b1),
                    model(3 * c + 1, 1'b0), model(3 * c + 1, 1'b1),
                    model(3 * c + 2, 1'b0), model(3 * c + 2, 1'b1), 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/angle_sincos.md
# angle_sincos

Converts the three rotation angles produced by the button/angle-accumulator stage (alpha, beta, gamma) into signed sine/cosine pairs for the downstream rotation-matrix stage. It uses one time-shared iterative CORDIC engine in rotation mode and processes alpha, beta, then gamma on each start request. It sits directly downstream of the angle accumulator. Its inputs are unsigned fixed-point degrees scaled by 2^23, so 360° = 3019898880 and one accumulator step (4915200) ≈ 0.586°.

## Interface
- ITERATIONS, 16, number of CORDIC micro-rotations per angle (legal range 12–20)
- OUT_WIDTH, 16, width of each signed sin/cos output in Q2.14 format (1.0 = 16384)
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  request conversion of the current i_alpha/i_beta/i_gamma
- i_alpha, i_beta, i_gamma  in  32 each  angles, unsigned, degrees × 2^23, nominally [0, 3019898880)
- o_busy  out  1  conversion in progress; i_start is ignored while high
- o_done  out  1  one-cycle pulse; all six results are updated in this cycle
- o_sin_alpha, o_cos_alpha, o_sin_beta, o_cos_beta, o_sin_gamma, o_cos_gamma  out  OUT_WIDTH each  signed Q2.14 results

## Operation
- On an i_start edge in IDLE, all three input angles are captured into internal registers. Later input changes do not affect the running conversion.
- Each angle is processed in three phases.
  - **REDUCE (1 cycle):**
    - If the angle is ≥ 360°, subtract 360° once.
    - Select quadrant q by comparing against 90° = 754974720, 180° = 1509949440 and 270° = 2264924160.
    - Set z = angle − q·90°, x = K = 9949 (round(0.6072529·16384)), y = 0.
  - **ITER (ITERATIONS cycles):**
    - Iteration i: d = sign(z).
    - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_tab[i].
    - atan_tab is in degrees × 2^23; atan_tab[0] = 377487360.
    - Internal x/y are at least OUT_WIDTH+4 bits; z is 33-bit signed.
  - **FIX (1 cycle):** map the reduced result (s = y, c = x) back to the original quadrant:
    - q0: sin = s, cos = c
    - q1: sin = c, cos = −s
    - q2: sin = −s, cos = −c
    - q3: sin = −c, cos = s
    - Round to OUT_WIDTH and saturate to ±16384. The result goes into a holding register for that angle.
- After the gamma FIX cycle, copy all three holding registers to the outputs and pulse o_done.
- State machine: IDLE → REDUCE → ITER → FIX → (REDUCE of next angle | OUTPUT) → IDLE.
  - An angle index 0..2 selects alpha, beta or gamma.
  - OUTPUT lasts 1 cycle and asserts o_done.
- Accuracy: each output within ±4 LSB of round(16384·sin/cos(θ)) for ITERATIONS = 16.

## Timing
- Reset values:
  - all outputs 0
  - o_busy = 0, o_done = 0
  - FSM in IDLE; holding registers 0
- i_start is sampled at edge T0 while in IDLE. o_busy goes high after T0.
- Per-angle cost is ITERATIONS + 2 cycles. o_done is high in the cycle after edge T0 + 3·(ITERATIONS+2) + 1, which is T0+55 for the default.
- o_busy falls in the same cycle o_done rises. A new i_start is accepted at the very next edge.
- i_start is level-sampled. Holding it high gives back-to-back conversions.
- Outputs are stable between o_done pulses.
- Reset asserted mid-conversion:
  - immediate return to IDLE
  - outputs cleared to 0
  - no o_done pulse

## Structure
- Package angle_pkg holds:
  - ANGLE_90, ANGLE_180, ANGLE_270, ANGLE_360 constants
  - CORDIC_K_Q14 = 9949
  - the atan_tab constant array (20 entries, degrees × 2^23)
  - the FSM state enum
- Sub-module cordic_step: purely combinational single micro-rotation, taking x, y, z and i, returning x', y', z'. The top level instantiates it once and registers its result each ITER cycle.

## Test plan
- **Reset:** assert reset for 5 cycles, including mid-conversion at T0+20.
  - All outputs read 0 during and after reset.
  - o_busy = 0, and no o_done follows.
- **Zero and quarter angles:** alpha = 0, beta = 754974720, gamma = 1509949440.
  - (0, 16384), (16384, 0), (0, −16384) as (sin, cos), each ±4.
  - o_done exactly at T0+55.
- **One step and wrap neighbour:** alpha = 4915200, beta = 3014983680, gamma = 2264924160.
  - sin ≈ 168 / cos ≈ 16383, sin ≈ −168 / cos ≈ 16383, and (−16384, 0), each ±4.
- **Input capture:** change all inputs at T0+5; results match the values captured at T0.
- **Busy handling:** pulse i_start at T0+10.
  - Ignored, and only one o_done occurs.
  - Holding i_start high gives o_done every 56 cycles.
- **Sweep:** for every multiple of 4915200 below 360°, check all outputs ±4 LSB against a real-valued model and check that the outputs never change except in o_done cycles.
